alarm_controller: RTL and testbench

- Sequences the alarm path: takes the committed mm:ss BCD alarm value from the alarm-set service, arms it, and compares it against the running clock once per second.
- On a match it drives the ring output, then handles snooze, dismiss and ring timeout.
- Sits between the alarm-set service, the timekeeping counter and the LED/buzzer output stage.

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/sec_downcounter.sv | 33 +++
 rtl/alarm_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_alarm_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types for the alarm path: FSM state encoding, BCD digit type and mm:ss validity check.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTING = 3'd1,
        ST_ARMED   = 3'd2,
        ST_RINGING = 3'd3,
        ST_SNOOZE  = 3'd4
    } alarm_state_e;

    typedef logic [3:0] bcd_digit_t;

    // 1 when every digit is a legal BCD value and the seconds tens digit is 0..5.
    function automatic logic bcd_mmss_valid(input logic [15:0] mmss);
        bcd_digit_t m1;
        bcd_digit_t m0;
        bcd_digit_t s1;
        bcd_digit_t s0;
        m1 = mmss[15:12];
        m0 = mmss[11:8];
        s1 = mmss[7:4];
        s0 = mmss[3:0];
        return (m1 <= 4'd9) && (m0 <= 4'd9) && (s1 <= 4'd5) && (s0 <= 4'd9);
    endfunction

endpackage

// File: rtl/sec_downcounter.sv
// 8-bit seconds down-counter: load, clear, decrement on tick; done flags the tick that sees a count of 1.
module sec_downcounter
    import alarm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic       done
);

    logic [7:0] cnt_r;

    // Count register; clear beats load beats decrement, and zero never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= 8'd0;
        end else if (clear) begin
            cnt_r <= 8'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (tick && (cnt_r != 8'd0)) begin
            cnt_r <= cnt_r - 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = tick & (cnt_r == 8'd1);

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: arms a committed mm:ss alarm, rings on match, handles snooze/dismiss/timeout.
// Optional ALARM_BLINK_EN makes the ring output pulse at 1 s on / 1 s off.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECS   = 30,
    parameter int unsigned SNOOZE_SECS = 10,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spdt2,
    input  logic        finish2,
    input  logic [15:0] alarm,
    input  logic [15:0] cur_time,
    input  logic        tick_1hz,
    input  logic        push_c,
    input  logic        push_u,
    output logic        ring,
    output logic        armed,
    output logic        alarm_err,
    output logic [2:0]  state,
    output logic [2:0]  snooze_left
);

    localparam logic [7:0] RING_LOAD   = 8'(RING_SECS);
    localparam logic [7:0] SNOOZE_LOAD = 8'(SNOOZE_SECS);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

    alarm_state_e state_r;
    alarm_state_e state_s;
    logic         finish2_q_r;
    logic         commit_s;
    logic [15:0]  alarm_q_r;
    logic         err_r;
    logic         err_s;
    logic [2:0]   left_r;
    logic [2:0]   left_s;
    logic         latch_s;
    logic         ring_load_s;
    logic         snz_load_s;
    logic         cnt_clr_s;
    logic         ring_done_s;
    logic         snz_done_s;
    logic         ring_tick_s;
    logic         snz_tick_s;
    logic         push_any_s;
    logic         match_s;
    logic         ring_r;
    logic         ring_s;
    logic         armed_r;
    logic         armed_s;

    assign commit_s   = finish2 & ~finish2_q_r;
    assign push_any_s = push_c | push_u;
    assign match_s    = tick_1hz & (cur_time == alarm_q_r);
    // A push in the same cycle swallows the tick, so counters only see unclaimed ticks.
    assign ring_tick_s = tick_1hz & ~push_any_s & (state_r == ST_RINGING);
    assign snz_tick_s  = tick_1hz & ~push_any_s & (state_r == ST_SNOOZE);

    sec_downcounter u_ring_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clr_s),
        .load     (ring_load_s),
        .load_val (RING_LOAD),
        .tick     (ring_tick_s),
        .done     (ring_done_s)
    );

    sec_downcounter u_snz_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clr_s),
        .load     (snz_load_s),
        .load_val (SNOOZE_LOAD),
        .tick     (snz_tick_s),
        .done     (snz_done_s)
    );

    // Next-state and side-effect decode for the alarm FSM.
    always_comb begin
        state_s     = state_r;
        err_s       = err_r;
        left_s      = left_r;
        latch_s     = 1'b0;
        ring_load_s = 1'b0;
        snz_load_s  = 1'b0;
        cnt_clr_s   = 1'b0;
        if ((state_r != ST_IDLE) && spdt2) begin
            state_s   = ST_SETTING;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (spdt2) begin
                        state_s = ST_SETTING;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SETTING: begin
                    if (commit_s) begin
                        if (!bcd_mmss_valid(alarm)) begin
                            state_s = ST_IDLE;
                            err_s   = 1'b1;
                        end else begin
                            state_s = ST_ARMED;
                            err_s   = 1'b0;
                            latch_s = 1'b1;
                            left_s  = SNOOZE_MAX;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (match_s) begin
                        state_s     = ST_RINGING;
                        ring_load_s = 1'b1;
                    end else begin
                        state_s = ST_ARMED;
                    end
                end
                ST_RINGING: begin
                    if (push_c) begin
                        state_s = ST_ARMED;
                        left_s  = SNOOZE_MAX;
                    end else if (push_u && (left_r != 3'd0)) begin
                        state_s    = ST_SNOOZE;
                        snz_load_s = 1'b1;
                        left_s     = left_r - 3'd1;
                    end else if (push_u) begin
                        state_s = ST_ARMED;
                        left_s  = SNOOZE_MAX;
                    end else if (ring_done_s) begin
                        state_s = ST_ARMED;
                        left_s  = SNOOZE_MAX;
                    end else begin
                        state_s = ST_RINGING;
                    end
                end
                ST_SNOOZE: begin
                    if (push_c) begin
                        state_s = ST_ARMED;
                        left_s  = SNOOZE_MAX;
                    end else if (snz_done_s) begin
                        state_s     = ST_RINGING;
                        ring_load_s = 1'b1;
                    end else begin
                        state_s = ST_SNOOZE;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    cnt_clr_s = 1'b1;
                end
            endcase
        end
    end

    assign armed_s = (state_s == ST_ARMED) || (state_s == ST_RINGING) || (state_s == ST_SNOOZE);

`ifdef ALARM_BLINK_EN
    logic blink_r;
    logic blink_s;

    // Blink phase: zeroed on entry to RINGING so the first ring second is audible.
    always_comb begin
        if (ring_load_s) begin
            blink_s = 1'b0;
        end else if (tick_1hz) begin
            blink_s = ~blink_r;
        end else begin
            blink_s = blink_r;
        end
    end

    // Blink phase register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_r <= 1'b0;
        end else begin
            blink_r <= blink_s;
        end
    end

    assign ring_s = (state_s == ST_RINGING) & ~blink_s;
`else
    assign ring_s = (state_s == ST_RINGING);
`endif

    // State, alarm latch, status and registered output flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            finish2_q_r <= 1'b0;
            alarm_q_r   <= 16'h0000;
            err_r       <= 1'b0;
            left_r      <= SNOOZE_MAX;
            ring_r      <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            finish2_q_r <= finish2;
            if (latch_s) begin
                alarm_q_r <= alarm;
            end else begin
                alarm_q_r <= alarm_q_r;
            end
            err_r       <= err_s;
            left_r      <= left_s;
            ring_r      <= ring_s;
            armed_r     <= armed_s;
        end
    end

    assign ring        = ring_r;
    assign armed       = armed_r;
    assign alarm_err   = err_r;
    assign state       = state_r;
    assign snooze_left = left_r;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: vector table plus hand sequences for timeout, snooze and reset.
module tb_alarm_controller;

    logic        clk;
    logic        reset;
    logic        spdt2;
    logic        finish2;
    logic [15:0] alarm;
    logic [15:0] cur_time;
    logic        tick_1hz;
    logic        push_c;
    logic        push_u;
    logic        ring;
    logic        armed;
    logic        alarm_err;
    logic [2:0]  state;
    logic [2:0]  snooze_left;

    int checks = 0;
    int errors = 0;

    alarm_controller dut (
        .clk         (clk),
        .reset       (reset),
        .spdt2       (spdt2),
        .finish2     (finish2),
        .alarm       (alarm),
        .cur_time    (cur_time),
        .tick_1hz    (tick_1hz),
        .push_c      (push_c),
        .push_u      (push_u),
        .ring        (ring),
        .armed       (armed),
        .alarm_err   (alarm_err),
        .state       (state),
        .snooze_left (snooze_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        s2;
        logic        f2;
        logic [15:0] al;
        logic [15:0] ct;
        logic        tk;
        logic        pc;
        logic        pu;
        logic        e_ring;
        logic        e_armed;
        logic        e_err;
        logic [2:0]  e_state;
        logic [2:0]  e_left;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic s2, input logic f2, input logic [15:0] al,
                                input logic [15:0] ct, input logic tk, input logic pc,
                                input logic pu, input logic r, input logic a, input logic e,
                                input logic [2:0] st, input logic [2:0] lf);
        vec_t v;
        v.s2 = s2; v.f2 = f2; v.al = al; v.ct = ct; v.tk = tk; v.pc = pc; v.pu = pu;
        v.e_ring = r; v.e_armed = a; v.e_err = e; v.e_state = st; v.e_left = lf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic check_outs(input string tag, input logic r, input logic a, input logic e,
                              input logic [2:0] st, input logic [2:0] lf);
        chk({tag, ".ring"}, 16'(ring), 16'(r));
        chk({tag, ".armed"}, 16'(armed), 16'(a));
        chk({tag, ".alarm_err"}, 16'(alarm_err), 16'(e));
        chk({tag, ".state"}, 16'(state), 16'(st));
        chk({tag, ".snooze_left"}, 16'(snooze_left), 16'(lf));
    endtask

    // One clock with the given inputs; pulses drop back to 0 right after the edge.
    task automatic cyc(input logic s2, input logic f2, input logic [15:0] al, input logic [15:0] ct,
                       input logic tk, input logic pc, input logic pu);
        spdt2 = s2; finish2 = f2; alarm = al; cur_time = ct;
        tick_1hz = tk; push_c = pc; push_u = pu;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0; push_c = 1'b0; push_u = 1'b0;
    endtask

    initial begin
        reset = 1'b0; spdt2 = 1'b0; finish2 = 1'b0; alarm = 16'h0000; cur_time = 16'h0000;
        tick_1hz = 1'b0; push_c = 1'b0; push_u = 1'b0;

        //              s2    f2    alarm     cur       tk    pc    pu    ring  armed err   state lf
        vecs[0]  = mk(1'b1, 1'b0, 16'h0130, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3);
        vecs[1]  = mk(1'b0, 1'b1, 16'h0130, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        vecs[2]  = mk(1'b0, 1'b1, 16'h0130, 16'h0129, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        vecs[3]  = mk(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        vecs[4]  = mk(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
        vecs[5]  = mk(1'b0, 1'b0, 16'h0130, 16'h0131, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
        vecs[6]  = mk(1'b0, 1'b0, 16'h0130, 16'h0132, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        vecs[7]  = mk(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
        vecs[8]  = mk(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 3'd2);
        vecs[9]  = mk(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        vecs[10] = mk(1'b1, 1'b0, 16'h0075, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3);
        vecs[11] = mk(1'b1, 1'b1, 16'h0075, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3);
        vecs[12] = mk(1'b0, 1'b1, 16'h0075, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3);
        vecs[13] = mk(1'b1, 1'b0, 16'h0075, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3);
        vecs[14] = mk(1'b0, 1'b1, 16'h0075, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3);
        vecs[15] = mk(1'b0, 1'b1, 16'h0075, 16'h0075, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3);
        vecs[16] = mk(1'b1, 1'b0, 16'h0A00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd3);
        vecs[17] = mk(1'b0, 1'b1, 16'h0A00, 16'h0A00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3);
        vecs[18] = mk(1'b1, 1'b0, 16'h5959, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd3);
        vecs[19] = mk(1'b0, 1'b1, 16'h5959, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        vecs[20] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        vecs[21] = mk(1'b0, 1'b0, 16'h0000, 16'h5959, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
        vecs[22] = mk(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3);

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 3'd0, 3'd3);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].s2, vecs[i].f2, vecs[i].al, vecs[i].ct, vecs[i].tk, vecs[i].pc, vecs[i].pu);
            check_outs($sformatf("vec%0d", i), vecs[i].e_ring, vecs[i].e_armed, vecs[i].e_err,
                       vecs[i].e_state, vecs[i].e_left);
        end

        // Ring timeout: 30 unattended ticks, then the same match rings again.
        cyc(1'b0, 1'b1, 16'h0130, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_outs("to_commit", 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        cyc(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b1, 1'b0, 1'b0);
        check_outs("to_match", 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
        for (int t = 1; t <= 29; t++) cyc(1'b0, 1'b0, 16'h0130, 16'h0131, 1'b1, 1'b0, 1'b0);
        check_outs("to_tick29", 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
        cyc(1'b0, 1'b0, 16'h0130, 16'h0131, 1'b1, 1'b0, 1'b0);
        check_outs("to_tick30", 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        cyc(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b1, 1'b0, 1'b0);
        check_outs("to_rering", 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);

        // Three snoozes 10 ticks apart, then a fourth snooze acts as dismiss.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 16'h0130, 16'h0200, (k == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            check_outs($sformatf("snz%0d_push", k), 1'b0, 1'b1, 1'b0, 3'd4, 3'(2 - k));
            for (int t = 1; t <= 9; t++) cyc(1'b0, 1'b0, 16'h0130, 16'h0200, 1'b1, 1'b0, 1'b0);
            check_outs($sformatf("snz%0d_t9", k), 1'b0, 1'b1, 1'b0, 3'd4, 3'(2 - k));
            cyc(1'b0, 1'b0, 16'h0130, 16'h0200, 1'b1, 1'b0, 1'b0);
            check_outs($sformatf("snz%0d_t10", k), 1'b1, 1'b1, 1'b0, 3'd3, 3'(2 - k));
        end
        cyc(1'b0, 1'b0, 16'h0130, 16'h0200, 1'b0, 1'b0, 1'b1);
        check_outs("snz_exhaust", 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);

        // Reset asserted mid-ring.
        cyc(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b1, 1'b0, 1'b0);
        check_outs("rst_ring", 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 16'h0130, 16'h0131, 1'b0, 1'b0, 1'b0);
        check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 3'd0, 3'd3);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b1, 1'b0, 1'b0);
        check_outs("rst_after", 1'b0, 1'b0, 1'b0, 3'd0, 3'd3);

        // Mode switch flipped while snoozing.
        cyc(1'b1, 1'b0, 16'h0130, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0130, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_outs("sw_commit", 1'b0, 1'b1, 1'b0, 3'd2, 3'd3);
        cyc(1'b0, 1'b0, 16'h0130, 16'h0130, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0130, 16'h0131, 1'b0, 1'b0, 1'b1);
        check_outs("sw_snooze", 1'b0, 1'b1, 1'b0, 3'd4, 3'd2);
        cyc(1'b1, 1'b0, 16'h0130, 16'h0132, 1'b1, 1'b0, 1'b0);
        check_outs("sw_setting", 1'b0, 1'b0, 1'b0, 3'd1, 3'd2);
        for (int t = 0; t < 12; t++) cyc(1'b1, 1'b0, 16'h0130, 16'h0133, 1'b1, 1'b0, 1'b0);
        check_outs("sw_hold", 1'b0, 1'b0, 1'b0, 3'd1, 3'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
